// File: rtl/level_crossing_ctrl_n.sv
// rtl/level_crossing_ctrl_n.sv - multi-track level-crossing controller
// Per-track wheel decoding at two stations, axle-occupancy counting and a warn/close/hold gate sequence.
module level_crossing_ctrl_n #(
  parameter int NUM_TRACKS  = 2,
  parameter int CNT_W       = 4,
  parameter int WARN_CYCLES = 8,
  parameter int HOLD_CYCLES = 16
) (
  input  logic                        Clk,
  input  logic                        Reset,
  input  logic [NUM_TRACKS-1:0]       st1_a,
  input  logic [NUM_TRACKS-1:0]       st1_b,
  input  logic [NUM_TRACKS-1:0]       st2_a,
  input  logic [NUM_TRACKS-1:0]       st2_b,
  output logic                        gate_open,
  output logic                        warn,
  output logic                        fault,
  output logic [NUM_TRACKS-1:0]       occupied,
  output logic [NUM_TRACKS*CNT_W-1:0] occ_ab,
  output logic [NUM_TRACKS*CNT_W-1:0] occ_ba
);

  localparam logic [2:0] W_IDLE = 3'd0;
  localparam logic [2:0] W_A1   = 3'd1;
  localparam logic [2:0] W_A2   = 3'd2;
  localparam logic [2:0] W_A3   = 3'd3;
  localparam logic [2:0] W_B1   = 3'd4;
  localparam logic [2:0] W_B2   = 3'd5;
  localparam logic [2:0] W_B3   = 3'd6;

  localparam logic [1:0] G_OPEN   = 2'd0;
  localparam logic [1:0] G_WARN   = 2'd1;
  localparam logic [1:0] G_CLOSED = 2'd2;
  localparam logic [1:0] G_HOLD   = 2'd3;

  localparam int TMR_MAX = (WARN_CYCLES > HOLD_CYCLES) ? WARN_CYCLES : HOLD_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 2);
  localparam logic [TMR_W-1:0] WARN_LOAD = TMR_W'(WARN_CYCLES - 1);
  localparam logic [TMR_W-1:0] HOLD_LOAD = TMR_W'(HOLD_CYCLES - 1);

  localparam int SN = NUM_TRACKS;

  // Returns {a2b_pulse, b2a_pulse, next_state}; anything off the two legal paths drops to IDLE.
  function automatic logic [4:0] wheel_next(input logic [2:0] st, input logic a, input logic b);
    logic [2:0] nx;
    logic       pab;
    logic       pba;
    nx  = W_IDLE;
    pab = 1'b0;
    pba = 1'b0;
    case (st)
      W_IDLE: begin
        if (a && !b)      nx = W_A1;
        else if (!a && b) nx = W_B1;
      end
      W_A1: begin
        if (a && !b)      nx = W_A1;
        else if (a && b)  nx = W_A2;
      end
      W_A2: begin
        if (a && b)       nx = W_A2;
        else if (!a && b) nx = W_A3;
      end
      W_A3: begin
        if (!a && b)       nx = W_A3;
        else if (!a && !b) pab = 1'b1;
      end
      W_B1: begin
        if (!a && b)      nx = W_B1;
        else if (a && b)  nx = W_B2;
      end
      W_B2: begin
        if (a && b)       nx = W_B2;
        else if (a && !b) nx = W_B3;
      end
      W_B3: begin
        if (a && !b)       nx = W_B3;
        else if (!a && !b) pba = 1'b1;
      end
      default: nx = W_IDLE;
    endcase
    return {pab, pba, nx};
  endfunction

  // Returns {error, next_count}; simultaneous inc and dec cancel out.
  function automatic logic [CNT_W:0] count_step(input logic [CNT_W-1:0] q, input logic inc,
                                                input logic dec);
    logic [CNT_W-1:0] nx;
    logic             err;
    nx  = q;
    err = 1'b0;
    if (inc && !dec) begin
      if (&q) err = 1'b1;
      else    nx  = q + CNT_W'(1);
    end else if (dec && !inc) begin
      if (q == '0) err = 1'b1;
      else         nx  = q - CNT_W'(1);
    end
    return {err, nx};
  endfunction

  logic [4*SN-1:0] sync_m;
  logic [4*SN-1:0] sync_q;
  logic [SN-1:0]   s1a, s1b, s2a, s2b;
  logic [SN-1:0]   cnt_err;
  logic [1:0]      g_state;
  logic [TMR_W-1:0] timer;
  logic            any_occ;

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      sync_m <= '0;
      sync_q <= '0;
    end else begin
      sync_m <= {st2_b, st2_a, st1_b, st1_a};
      sync_q <= sync_m;
    end
  end

  assign s1a = sync_q[0*SN +: SN];
  assign s1b = sync_q[1*SN +: SN];
  assign s2a = sync_q[2*SN +: SN];
  assign s2b = sync_q[3*SN +: SN];

  for (genvar t = 0; t < NUM_TRACKS; t++) begin : g_track
    logic [2:0]       w1_q, w2_q;
    logic             p1_ab, p1_ba, p2_ab, p2_ba;
    logic [4:0]       w1_nx, w2_nx;
    logic [CNT_W-1:0] ab_q, ba_q;
    logic [CNT_W:0]   ab_step, ba_step;

    assign w1_nx = wheel_next(w1_q, s1a[t], s1b[t]);
    assign w2_nx = wheel_next(w2_q, s2a[t], s2b[t]);

    always_ff @(posedge Clk) begin
      if (!Reset) begin
        {p1_ab, p1_ba, w1_q} <= '0;
        {p2_ab, p2_ba, w2_q} <= '0;
      end else begin
        {p1_ab, p1_ba, w1_q} <= w1_nx;
        {p2_ab, p2_ba, w2_q} <= w2_nx;
      end
    end

    // a2b traffic enters at ST1 and leaves at ST2; b2a the other way round.
    assign ab_step = count_step(ab_q, p1_ab, p2_ab);
    assign ba_step = count_step(ba_q, p2_ba, p1_ba);

    always_ff @(posedge Clk) begin
      if (!Reset) begin
        ab_q <= '0;
        ba_q <= '0;
      end else begin
        ab_q <= ab_step[CNT_W-1:0];
        ba_q <= ba_step[CNT_W-1:0];
      end
    end

    assign cnt_err[t]                 = ab_step[CNT_W] | ba_step[CNT_W];
    assign occupied[t]                = (ab_q != '0) || (ba_q != '0);
    assign occ_ab[t*CNT_W +: CNT_W]   = ab_q;
    assign occ_ba[t*CNT_W +: CNT_W]   = ba_q;
  end

  always_ff @(posedge Clk) begin
    if (!Reset) fault <= 1'b0;
    else if (|cnt_err) fault <= 1'b1;
  end

  assign any_occ = |occupied;

  // A latched fault pins the barrier down until reset, whatever the occupancy says.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      g_state <= G_OPEN;
      timer   <= '0;
    end else if (fault) begin
      g_state <= G_CLOSED;
    end else begin
      case (g_state)
        G_OPEN: begin
          if (any_occ) begin
            g_state <= G_WARN;
            timer   <= WARN_LOAD;
          end
        end
        G_WARN: begin
          if (timer == '0) g_state <= G_CLOSED;
          else             timer   <= timer - TMR_W'(1);
        end
        G_CLOSED: begin
          if (!any_occ) begin
            g_state <= G_HOLD;
            timer   <= HOLD_LOAD;
          end
        end
        G_HOLD: begin
          if (any_occ)          g_state <= G_CLOSED;
          else if (timer == '0) g_state <= G_OPEN;
          else                  timer   <= timer - TMR_W'(1);
        end
        default: g_state <= G_CLOSED;
      endcase
    end
  end

  assign gate_open = (g_state == G_OPEN) || (g_state == G_WARN);
  assign warn      = (g_state != G_OPEN);

endmodule

// File: tb/tb_level_crossing_ctrl_n.sv
// tb/tb_level_crossing_ctrl_n.sv - directed self-checking bench for level_crossing_ctrl_n
// Second instance uses CNT_W=2 for the saturation case.
module tb_level_crossing_ctrl_n;

  logic       Clk;
  logic       Reset;
  logic [1:0] st1_a, st1_b, st2_a, st2_b;
  logic       gate_open, warn, fault;
  logic [1:0] occupied;
  logic [7:0] occ_ab, occ_ba;

  logic [1:0] d2_st1_a, d2_st1_b, d2_st2_a, d2_st2_b;
  logic       d2_gate_open, d2_warn, d2_fault;
  logic [1:0] d2_occupied;
  logic [3:0] d2_occ_ab, d2_occ_ba;

  int vectors;
  int miscompares;
  logic [31:0] r;

  level_crossing_ctrl_n #(.NUM_TRACKS(2), .CNT_W(4), .WARN_CYCLES(8), .HOLD_CYCLES(16)) dut (
    .Clk(Clk), .Reset(Reset),
    .st1_a(st1_a), .st1_b(st1_b), .st2_a(st2_a), .st2_b(st2_b),
    .gate_open(gate_open), .warn(warn), .fault(fault),
    .occupied(occupied), .occ_ab(occ_ab), .occ_ba(occ_ba)
  );

  level_crossing_ctrl_n #(.NUM_TRACKS(2), .CNT_W(2), .WARN_CYCLES(2), .HOLD_CYCLES(3)) dut2 (
    .Clk(Clk), .Reset(Reset),
    .st1_a(d2_st1_a), .st1_b(d2_st1_b), .st2_a(d2_st2_a), .st2_b(d2_st2_b),
    .gate_open(d2_gate_open), .warn(d2_warn), .fault(d2_fault),
    .occupied(d2_occupied), .occ_ab(d2_occ_ab), .occ_ba(d2_occ_ba)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic step(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_pat(input int which, input logic [1:0] smask, input logic [1:0] tmask,
                         input logic a, input logic b);
    for (int t = 0; t < 2; t++) begin
      if (tmask[t]) begin
        if (which == 1) begin
          if (smask[0]) begin st1_a[t] = a; st1_b[t] = b; end
          if (smask[1]) begin st2_a[t] = a; st2_b[t] = b; end
        end else begin
          if (smask[0]) begin d2_st1_a[t] = a; d2_st1_b[t] = b; end
          if (smask[1]) begin d2_st2_a[t] = a; d2_st2_b[t] = b; end
        end
      end
    end
  endtask

  // One axle, one cycle per pattern; returns 1ns after the edge that samples the closing idle.
  task automatic pass_axle(input int which, input logic [1:0] smask, input logic [1:0] tmask,
                           input bit ab);
    logic [3:0] pa;
    logic [3:0] pb;
    pa = ab ? 4'b1100 : 4'b0110;
    pb = ab ? 4'b0110 : 4'b1100;
    for (int i = 0; i < 4; i++) begin
      set_pat(which, smask, tmask, pa[3-i], pb[3-i]);
      step(1);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    d2_st1_a = '0; d2_st1_b = '0; d2_st2_a = '0; d2_st2_b = '0;

    // T1 reset with random sensor activity
    Reset = 1'b0;
    r = $urandom;
    st1_a = r[1:0]; st1_b = r[3:2]; st2_a = r[5:4]; st2_b = r[7:6];
    step(1);
    r = $urandom;
    st1_a = r[1:0]; st1_b = r[3:2]; st2_a = r[5:4]; st2_b = r[7:6];
    step(1);
    check("t1_gate_open", {31'd0, gate_open}, 32'd1);
    check("t1_warn", {31'd0, warn}, 32'd0);
    check("t1_fault", {31'd0, fault}, 32'd0);
    check("t1_occupied", {30'd0, occupied}, 32'd0);
    check("t1_occ_ab", {24'd0, occ_ab}, 32'd0);
    check("t1_occ_ba", {24'd0, occ_ba}, 32'd0);
    st1_a = '0; st1_b = '0; st2_a = '0; st2_b = '0;
    Reset = 1'b1;
    step(3);
    check("t1_post_release", {30'd0, gate_open, warn}, 32'h2);

    // T2 three-axle a2b train on track 0
    pass_axle(1, 2'b01, 2'b01, 1'b1);
    step(3);
    check("t2_occ_1", {28'd0, occ_ab[3:0]}, 32'd1);
    check("t2_occupied", {30'd0, occupied}, 32'd1);
    check("t2_warn_k3", {31'd0, warn}, 32'd0);
    step(1);
    check("t2_warn_k4", {31'd0, warn}, 32'd1);
    check("t2_open_k4", {31'd0, gate_open}, 32'd1);
    step(7);
    check("t2_open_warn7", {31'd0, gate_open}, 32'd1);
    step(1);
    check("t2_closed_warn8", {30'd0, gate_open, warn}, 32'h1);
    pass_axle(1, 2'b01, 2'b01, 1'b1);
    step(3);
    check("t2_occ_2", {28'd0, occ_ab[3:0]}, 32'd2);
    pass_axle(1, 2'b01, 2'b01, 1'b1);
    step(3);
    check("t2_occ_3", {28'd0, occ_ab[3:0]}, 32'd3);
    pass_axle(1, 2'b10, 2'b01, 1'b1);
    step(3);
    check("t2_occ_dn2", {28'd0, occ_ab[3:0]}, 32'd2);
    pass_axle(1, 2'b10, 2'b01, 1'b1);
    step(3);
    check("t2_occ_dn1", {28'd0, occ_ab[3:0]}, 32'd1);
    pass_axle(1, 2'b10, 2'b01, 1'b1);
    step(3);
    check("t2_occ_dn0", {28'd0, occ_ab[3:0]}, 32'd0);
    check("t2_unocc_closed", {30'd0, gate_open, warn}, 32'h1);
    step(1);
    check("t2_hold_entry", {30'd0, gate_open, warn}, 32'h1);
    step(15);
    check("t2_hold_15", {31'd0, gate_open}, 32'd0);
    step(1);
    check("t2_hold_16_open", {30'd0, gate_open, warn}, 32'h2);
    check("t2_fault", {31'd0, fault}, 32'd0);

    // T3 back-out at ST1
    set_pat(1, 2'b01, 2'b01, 1'b1, 1'b0); step(1);
    set_pat(1, 2'b01, 2'b01, 1'b1, 1'b1); step(1);
    set_pat(1, 2'b01, 2'b01, 1'b1, 1'b0); step(1);
    set_pat(1, 2'b01, 2'b01, 1'b0, 1'b0); step(6);
    check("t3_occ_ab", {24'd0, occ_ab}, 32'd0);
    check("t3_occ_ba", {24'd0, occ_ba}, 32'd0);
    check("t3_gate", {29'd0, fault, gate_open, warn}, 32'h2);

    // T6b track 0 clears in HOLD while track 1 becomes occupied
    pass_axle(1, 2'b01, 2'b01, 1'b1);
    step(14);
    check("t6b_closed", {30'd0, gate_open, warn}, 32'h1);
    pass_axle(1, 2'b10, 2'b01, 1'b1);
    pass_axle(1, 2'b01, 2'b10, 1'b1);
    check("t6b_in_hold", {29'd0, gate_open, occupied}, 32'd0);
    step(4);
    check("t6b_trk1_occ", {30'd0, occupied}, 32'h2);
    step(20);
    check("t6b_stays_closed", {30'd0, gate_open, warn}, 32'h1);

    // T4 same-cycle enter and leave on track 1 at count 2
    pass_axle(1, 2'b01, 2'b10, 1'b1);
    step(3);
    check("t4_occ_pre", {28'd0, occ_ab[7:4]}, 32'd2);
    pass_axle(1, 2'b11, 2'b10, 1'b1);
    step(3);
    check("t4_occ_same", {28'd0, occ_ab[7:4]}, 32'd2);
    check("t4_fault", {31'd0, fault}, 32'd0);

    // b2a on both tracks in the same cycle
    pass_axle(1, 2'b10, 2'b11, 1'b0);
    step(3);
    check("ba_both_in", {24'd0, occ_ba}, 32'h11);
    pass_axle(1, 2'b01, 2'b11, 1'b0);
    step(3);
    check("ba_both_out", {24'd0, occ_ba}, 32'h00);
    check("ba_fault", {31'd0, fault}, 32'd0);

    pass_axle(1, 2'b10, 2'b10, 1'b1);
    pass_axle(1, 2'b10, 2'b10, 1'b1);
    step(3);
    check("clr_occ_ab", {24'd0, occ_ab}, 32'd0);
    step(20);
    check("clr_reopen", {30'd0, gate_open, warn}, 32'h2);

    // T5 underflow fault
    pass_axle(1, 2'b10, 2'b01, 1'b1);
    step(3);
    check("t5_occ", {28'd0, occ_ab[3:0]}, 32'd0);
    check("t5_fault", {31'd0, fault}, 32'd1);
    check("t5_open_k3", {31'd0, gate_open}, 32'd1);
    step(1);
    check("t5_closed_k4", {30'd0, gate_open, warn}, 32'h1);
    step(30);
    check("t5_stays_closed", {29'd0, fault, gate_open, warn}, 32'h5);
    Reset = 1'b0;
    step(2);
    check("t5_reset", {29'd0, fault, gate_open, warn}, 32'h2);
    Reset = 1'b1;
    step(2);
    check("t5_after_reset", {29'd0, fault, gate_open, warn}, 32'h2);

    // T6 saturation with CNT_W=2
    for (int i = 0; i < 4; i++) begin
      pass_axle(2, 2'b01, 2'b01, 1'b1);
      step(3);
      check($sformatf("t6_sat_occ_%0d", i), {28'd0, d2_occ_ab}, (i < 3) ? i + 1 : 3);
      check($sformatf("t6_sat_fault_%0d", i), {31'd0, d2_fault}, (i < 3) ? 32'd0 : 32'd1);
    end
    step(1);
    check("t6_gate", {30'd0, d2_gate_open, d2_warn}, 32'h1);
    check("t6_occ_ba", {26'd0, d2_occupied, d2_occ_ba}, 32'h10);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
